// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared types and helpers for the memory-access stage
// Revision      : 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  function automatic logic [3:0] size_to_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

  // Only the low three address bits matter for transfers of at most 8 bytes.
  function automatic logic is_aligned(input logic [2:0] lsb, input size_e sz);
    logic ok;
    unique case (sz)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (lsb[0] == 1'b0);
      SZ_W:    ok = (lsb[1:0] == 2'b00);
      default: ok = (lsb == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_ctrl_load_extend.sv
// ============================================================================
// load_extend : sign/zero extension of right-justified load data
// Revision    : 1.0
// ============================================================================
`default_nettype none

module load_extend
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  size_e             size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext
);

  localparam int H_MSB = ((DATA_W < 16) ? DATA_W : 16) - 1;
  localparam int W_MSB = ((DATA_W < 32) ? DATA_W : 32) - 1;

  int   nbits;
  logic fill;

  always_comb begin
    nbits = DATA_W;
    fill  = 1'b0;
    ext   = '0;
    unique case (size)
      SZ_B:    begin nbits = 8;      fill = rdata[7];        end
      SZ_H:    begin nbits = 16;     fill = rdata[H_MSB];    end
      SZ_W:    begin nbits = 32;     fill = rdata[W_MSB];    end
      default: begin nbits = DATA_W; fill = rdata[DATA_W-1]; end
    endcase
    fill = fill & sign_ext;
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i < nbits) ? rdata[i] : fill;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// mem_stage_ctrl : handshaked load/store/ALU-passthrough memory stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_mem_to_reg,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_xfer_size,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e              r_state;
  state_e              w_next;
  logic                r_is_read;
  logic                r_to_reg;
  logic                r_signed;
  size_e               r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;

  size_e               w_in_size;
  logic                w_accept;
  logic                w_is_alu;
  logic                w_fault_in;
  logic                w_expire;
  logic [DATA_W-1:0]   w_ext;

  assign w_in_size  = size_e'(in_size);
  assign in_ready   = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_alu   = !in_mem_read && !in_mem_write;
  assign w_fault_in = (in_mem_read && in_mem_write) || !is_aligned(in_addr[2:0], w_in_size);
  // An ack arriving in the expiring cycle takes priority over the timeout.
  assign w_expire   = (r_state == ISSUE) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign out_valid  = (r_state == HOLD);

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata    (mem_rdata),
    .size     (r_size),
    .sign_ext (r_signed),
    .ext      (w_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = (w_is_alu || w_fault_in) ? HOLD : ISSUE;
      end
      ISSUE: begin
        if (mem_ack || w_expire) w_next = HOLD;
      end
      default: begin
        if (out_ready) begin
          if (w_accept) w_next = (w_is_alu || w_fault_in) ? HOLD : ISSUE;
          else          w_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_read     <= 1'b0;
      r_to_reg      <= 1'b0;
      r_signed      <= 1'b0;
      r_size        <= SZ_B;
      r_addr        <= '0;
      r_cnt         <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_xfer_size <= '0;
      out_data      <= '0;
      out_tag       <= '0;
      out_fault     <= 1'b0;
    end else if (w_accept) begin
      r_is_read <= in_mem_read;
      r_to_reg  <= in_mem_to_reg;
      r_signed  <= in_signed;
      r_size    <= w_in_size;
      r_addr    <= in_addr;
      r_cnt     <= '0;
      out_tag   <= in_tag;
      if (w_is_alu) begin
        out_data  <= DATA_W'(in_addr);
        out_fault <= 1'b0;
      end else if (w_fault_in) begin
        out_data  <= '0;
        out_fault <= 1'b1;
      end else begin
        mem_req       <= 1'b1;
        mem_we        <= in_mem_write;
        mem_addr      <= in_addr;
        mem_wdata     <= in_wdata;
        mem_xfer_size <= size_to_bytes(w_in_size);
      end
    end else if (r_state == ISSUE) begin
      if (mem_ack) begin
        mem_req   <= 1'b0;
        out_fault <= 1'b0;
        out_data  <= (r_is_read && r_to_reg) ? w_ext : DATA_W'(r_addr);
      end else if (w_expire) begin
        mem_req   <= 1'b0;
        out_fault <= 1'b1;
        out_data  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised, handshaked memory-access stage between execute and writeback.
- Accepts one op per handshake: ALU passthrough, load or store.
- Drives a variable-latency data-memory port (req/ack) with byte/half/word/dword transfer sizes, and sign- or zero-extends loads.
- Selects ALU result or extended load data as the writeback value; reports misalignment, illegal-op and timeout faults instead of hanging.

Parameters:
- DATA_W, 64, data path width; multiple of 8, at most 64.
- ADDR_W, 64, address width.
- TAG_W, 5, destination-register tag width.
- TIMEOUT_CYC, 16, cycles a memory request waits for mem_ack before faulting; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept an op this cycle.
- in_mem_read  in  1  op is a load.
- in_mem_write  in  1  op is a store.
- in_mem_to_reg  in  1  1 = writeback load data; 0 = writeback in_addr (ALU result).
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- in_signed  in  1  sign-extend load data.
- in_addr  in  ADDR_W  address / ALU result.
- in_wdata  in  DATA_W  store data, right-justified.
- in_tag  in  TAG_W  destination tag.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_xfer_size  out  4  transfer size in bytes: 1, 2, 4 or 8.
- mem_ack  in  1  request completed; mem_rdata valid this cycle for reads.
- mem_rdata  in  DATA_W  read data, right-justified.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  writeback value.
- out_tag  out  TAG_W  destination tag.
- out_fault  out  1  op faulted; out_data is 0.

Behaviour:
- Reset (async assert, sync release): state IDLE. in_ready=1. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_xfer_size=0. out_valid=0, out_data=0, out_tag=0, out_fault=0. Timeout counter=0.
- Reset mid-operation: any outstanding request is abandoned, mem_req drops immediately, and a late mem_ack is ignored.
- States: IDLE, ISSUE, HOLD.
- Accept = in_valid && in_ready. in_ready = (state==IDLE) || (state==HOLD && out_ready). ISSUE never accepts.
- On accept, all in_* fields are registered:
  - Neither read nor write: go to HOLD next cycle. out_data = in_addr truncated or zero-extended to DATA_W. 1-cycle latency.
  - Read and write both set: illegal. Go to HOLD with out_fault=1; no memory access.
  - Misaligned (addr mod 2^size != 0): go to HOLD with out_fault=1; no memory access.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req=1, and mem_we, mem_addr, mem_wdata, mem_xfer_size are held stable until mem_ack.
  - mem_ack sampled in the first ISSUE cycle is legal, giving a minimum 2-cycle latency from accept to out_valid.
  - On mem_ack: mem_req drops next cycle. For a load, capture the extended mem_rdata. Go to HOLD.
  - Load extension: keep the low 8<<size bits. When in_signed=1, replicate bit (8<<size)-1 to DATA_W; otherwise zero-fill.
  - out_data for a load = in_mem_to_reg ? extended data : in_addr.
  - Stores: out_data = in_addr; out_valid still pulses so the writeback/commit handshake stays uniform.
  - Timeout: counter resets on entry to ISSUE and increments each cycle without ack. When it reaches TIMEOUT_CYC, drop mem_req, go to HOLD with out_fault=1, out_data=0.
  - mem_ack in the same cycle the counter expires: ack wins, no fault.
- HOLD:
  - out_valid=1; out_data, out_tag and out_fault are stable until out_ready.
  - out_ready with no new accept: return to IDLE.
  - out_ready with a simultaneous accept: load the new op directly (back-to-back, no bubble).
- mem_ack outside ISSUE is ignored.

Decomposition:
- Package mem_stage_pkg holds:
  - size_e enum {SZ_B, SZ_H, SZ_W, SZ_D}.
  - state_e enum {IDLE, ISSUE, HOLD}.
  - Function size_to_bytes (size_e → 4-bit byte count).
  - Function is_aligned.
- One combinational sub-module, load_extend (DATA_W param; inputs rdata, size, signed; output ext).

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 → in_ready=1, mem_req=0, out_valid=0; deassert and accept ALU op addr=0x1234, tag=3 → next cycle out_valid=1, out_data=0x1234, out_tag=3.
- Signed byte load: addr=0x1001, size=0, signed=1; ack on 1st ISSUE cycle with rdata=0x80 → out_data=0xFFFF_FFFF_FFFF_FF80. Same with signed=0 → 0x80. Half load rdata=0xBEEF, unsigned → 0xBEEF.
- Store with delayed ack: addr=0x20, size=3, wdata=0xDEADBEEF; ack after 3 ISSUE cycles → mem_req high exactly 3 cycles with fields stable, mem_we=1, xfer=8; out_valid with out_fault=0.
- Misaligned and illegal ops: word load at 0x1002 → mem_req never asserts, out_fault=1, out_data=0. Read+write both set → same.
- Timeout: load, never ack, TIMEOUT_CYC=16 → mem_req high 16 cycles then low, out_fault=1. Variant with ack on the 16th cycle → no fault.
- Backpressure and back-to-back: out_ready=0 for 5 cycles → outputs stable, in_ready=0. Raise out_ready with in_valid=1 → new op accepted same cycle, no idle cycle between results. Assert reset_n=0 mid-ISSUE → mem_req drops immediately.
